// File: rtl/pwm_duty_gen4.sv
`default_nettype none
// ============================================================================
// pwm_duty_gen4 : 16-step PWM; handshaked duty is swapped in only at period
//                 boundaries. Optional PWM_SEG_EN adds the seg_duty display.
// Revision      : 1.0
// ============================================================================
module pwm_duty_gen4 #(
  parameter int PRESC_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] duty_in,
  input  logic       borrow_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  output logic [3:0] duty_act,
  output logic       pwm_out,
  output logic       period_start,
`ifdef PWM_SEG_EN
  output logic [6:0] seg_duty,
`endif
  output logic       err_underflow
);

  localparam int                   c_presc_w   = $clog2(PRESC_DIV);
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(PRESC_DIV - 1);
  localparam logic [c_presc_w-1:0] c_presc_one = c_presc_w'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [c_presc_w-1:0] presc_q, presc_d;
  logic                 pend_q, pend_d;
  logic [3:0]           pend_val_q, pend_val_d;
  logic [3:0]           duty_act_q, duty_act_d;
  logic                 period_start_q, period_start_d;
  logic                 err_q, err_d;
  logic                 tick;

  assign tick = (state_q == RUN) && (presc_q == c_presc_max);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    presc_d        = presc_q;
    pend_d         = pend_q;
    pend_val_d     = pend_val_q;
    duty_act_d     = duty_act_q;
    period_start_d = 1'b0;
    err_d          = err_q;

    // A transfer can only happen with pend_q=0, so it never races a swap.
    if (duty_valid && !pend_q) begin
      pend_d     = 1'b1;
      pend_val_d = borrow_in ? 4'd0 : duty_in;
      if (borrow_in) begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d   = 4'd0;
        presc_d = '0;
        if (en) begin
          state_d        = RUN;
          period_start_d = 1'b1;
          if (pend_q) begin
            duty_act_d = pend_val_q;
            pend_d     = 1'b0;
          end
        end
      end
      default: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            period_start_d = 1'b1;
            if (pend_q) begin
              duty_act_d = pend_val_q;
              pend_d     = 1'b0;
            end
          end
        end else begin
          presc_d = presc_q + c_presc_one;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      presc_q        <= '0;
      pend_q         <= 1'b0;
      pend_val_q     <= 4'd0;
      duty_act_q     <= 4'd0;
      period_start_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      presc_q        <= presc_d;
      pend_q         <= pend_d;
      pend_val_q     <= pend_val_d;
      duty_act_q     <= duty_act_d;
      period_start_q <= period_start_d;
      err_q          <= err_d;
    end
  end

  assign duty_ready    = !pend_q;
  assign duty_act      = duty_act_q;
  assign period_start  = period_start_q;
  assign err_underflow = err_q;
  assign pwm_out       = (state_q == RUN) && (cnt_q < duty_act_q);

`ifdef PWM_SEG_EN
  // Active-low, segment order {g,f,e,d,c,b,a}.
  always_comb begin
    seg_duty = 7'b1111111;
    case (duty_act_q)
      4'h0: seg_duty = 7'b1000000;
      4'h1: seg_duty = 7'b1111001;
      4'h2: seg_duty = 7'b0100100;
      4'h3: seg_duty = 7'b0110000;
      4'h4: seg_duty = 7'b0011001;
      4'h5: seg_duty = 7'b0010010;
      4'h6: seg_duty = 7'b0000010;
      4'h7: seg_duty = 7'b1111000;
      4'h8: seg_duty = 7'b0000000;
      4'h9: seg_duty = 7'b0010000;
      4'hA: seg_duty = 7'b0001000;
      4'hB: seg_duty = 7'b0000011;
      4'hC: seg_duty = 7'b1000110;
      4'hD: seg_duty = 7'b0100001;
      4'hE: seg_duty = 7'b0000110;
      default: seg_duty = 7'b0001110;
    endcase
  end
`endif

endmodule
`default_nettype wire
